// File: rtl/tthbif_cfg_ctrl.sv
// UART-driven configuration controller: parses read/write command bytes and drives lane tap selects.
// Optional macro TTHBIF_CFG_WRITE_ACK_EN: successful writes answer with ack byte 0xA5.
module tthbif_cfg_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       rx_data_valid_i,
  input  logic [7:0] rx_data_i,
  input  logic       tx_data_ready_i,
  output logic       tx_data_valid_o,
  output logic [7:0] tx_data_o,
  output logic [1:0] rx_flop_tap_sel_o,
  output logic [1:0] rx_comb_tap_sel_o,
  output logic [1:0] tx_flop_tap_sel_o,
  output logic [1:0] tx_comb_tap_sel_o,
  output logic       lane_en_o,
  output logic       busy_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] ERR_BYTE = 8'hEE;
  localparam logic [7:0] ACK_BYTE = 8'hA5;
  localparam logic [7:0] ID_BYTE  = 8'hB1;

  typedef enum logic [1:0] {IDLE, WDATA, RESP} state_t;

  state_t          state_q, state_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [1:0]      rx_flop_q, rx_flop_d;
  logic [1:0]      rx_comb_q, rx_comb_d;
  logic [1:0]      tx_flop_q, tx_flop_d;
  logic [1:0]      tx_comb_q, tx_comb_d;
  logic            lane_en_q, lane_en_d;
  logic [2:0]      addr_q, addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      rd_data;

  // Readback value for the address carried in the incoming command byte
  always_comb begin
    rd_data = ERR_BYTE;
    case (rx_data_i[2:0])
      3'd0:    rd_data = {6'b0, rx_flop_q};
      3'd1:    rd_data = {6'b0, rx_comb_q};
      3'd2:    rd_data = {6'b0, tx_flop_q};
      3'd3:    rd_data = {6'b0, tx_comb_q};
      3'd4:    rd_data = {7'b0, lane_en_q};
      3'd5:    rd_data = ID_BYTE;
      default: rd_data = ERR_BYTE;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    rx_flop_d  = rx_flop_q;
    rx_comb_d  = rx_comb_q;
    tx_flop_d  = tx_flop_q;
    tx_comb_d  = tx_comb_q;
    lane_en_d  = lane_en_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    if (!en_i) begin
      state_d    = IDLE;
      tx_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_data_valid_i) begin
            if (rx_data_i[6:3] != 4'd0) begin
              tx_data_d  = ERR_BYTE;
              tx_valid_d = 1'b1;
              state_d    = RESP;
            end else if (rx_data_i[7]) begin
              addr_d  = rx_data_i[2:0];
              cnt_d   = '0;
              state_d = WDATA;
            end else begin
              tx_data_d  = rd_data;
              tx_valid_d = 1'b1;
              state_d    = RESP;
            end
          end
        end
        WDATA: begin
          if (rx_data_valid_i) begin
            if (addr_q > 3'd4) begin
              tx_data_d  = ERR_BYTE;
              tx_valid_d = 1'b1;
              state_d    = RESP;
            end else begin
              case (addr_q)
                3'd0:    rx_flop_d = rx_data_i[1:0];
                3'd1:    rx_comb_d = rx_data_i[1:0];
                3'd2:    tx_flop_d = rx_data_i[1:0];
                3'd3:    tx_comb_d = rx_data_i[1:0];
                default: lane_en_d = rx_data_i[0];
              endcase
`ifdef TTHBIF_CFG_WRITE_ACK_EN
              tx_data_d  = ACK_BYTE;
              tx_valid_d = 1'b1;
              state_d    = RESP;
`else
              state_d    = IDLE;
`endif
            end
          end else if (cnt_q >= CNT_LAST) begin
            // Leaving at the last count keeps the counter from ever wrapping
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (tx_valid_q && tx_data_ready_i) begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      rx_flop_q  <= '1;
      rx_comb_q  <= '1;
      tx_flop_q  <= '1;
      tx_comb_q  <= '1;
      lane_en_q  <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      rx_flop_q  <= rx_flop_d;
      rx_comb_q  <= rx_comb_d;
      tx_flop_q  <= tx_flop_d;
      tx_comb_q  <= tx_comb_d;
      lane_en_q  <= lane_en_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign tx_data_valid_o   = tx_valid_q;
  assign tx_data_o         = tx_data_q;
  assign rx_flop_tap_sel_o = rx_flop_q;
  assign rx_comb_tap_sel_o = rx_comb_q;
  assign tx_flop_tap_sel_o = tx_flop_q;
  assign tx_comb_tap_sel_o = tx_comb_q;
  assign lane_en_o         = lane_en_q;
  assign busy_o            = (state_q != IDLE);

endmodule
